// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and divide unit with a start/done handshake.
// It runs one shift-add or restoring shift-subtract step per clock and registers the result in hi/lo.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   One  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] One2 = (2*WIDTH)'(1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // partial product high half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;     // multiplier shifting out / dividend -> quotient
    logic [WIDTH-1:0] opnd_q, opnd_d; // multiplicand or divisor magnitude
    logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, div_zero_q, div_zero_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod;

    // Magnitudes are WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1) exactly.
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + One) : a;
    assign b_mag = b_neg ? (~b + One) : b;

    assign mul_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opnd_q : '0)};
    assign div_shift = {acc_q, mq_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign prod      = neg_lo_q ? (~{acc_q, mq_q} + One2) : {acc_q, mq_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        opnd_d     = opnd_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        case (state_q)
            StIdle: begin
                // The done cycle is not an accepting cycle.
                if (start && !done_q) begin
                    is_div_d   = op[1];
                    acc_d      = '0;
                    mq_d       = op[1] ? a_mag : b_mag;
                    opnd_d     = op[1] ? b_mag : a_mag;
                    neg_lo_d   = a_neg ^ b_neg;
                    neg_hi_d   = op[1] ? a_neg : (a_neg ^ b_neg);
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    dz_d       = op[1] && (b == '0);
                    state_d    = (op[1] && (b == '0)) ? StFin : StRun;
                end
            end
            StRun: begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StFin: begin
                // Divide-by-zero spends one extra cycle here so it completes two edges after start.
                if (dz_q && (cnt_q == '0)) begin
                    cnt_d = CW'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                    if (dz_q) begin
                        div_zero_d = 1'b1;
                    end else if (is_div_q) begin
                        lo_d = neg_lo_q ? (~mq_q + One) : mq_q;
                        hi_d = neg_hi_q ? (~acc_q + One) : acc_q;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            acc_q      <= '0;
            mq_q       <= '0;
            opnd_q     <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            opnd_q     <= opnd_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed cases plus random operations
// checked every cycle against a latency/arithmetic reference model.
module tb_muldiv_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int n_pass  = 0;
    int n_total = 0;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Exact results from plain 64-bit arithmetic: {hi, lo}.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy, q, rm, p;
        logic [63:0] r;
        sx = $signed(x);
        sy = $signed(y);
        r  = '0;
        case (o)
            2'd0: begin p = sx * sy; r = p; end
            2'd1: r = {32'b0, x} * {32'b0, y};
            2'd2: if (y != 0) begin q = sx / sy; rm = sx % sy; r = {rm[31:0], q[31:0]}; end
            default: if (y != 0) r = {x % y, x / y};
        endcase
        return r;
    endfunction

    // Reference model: operation timing as a countdown of cycles to completion.
    logic        m_busy, m_done, m_dz, p_dz;
    logic [31:0] m_hi, m_lo;
    logic [63:0] p_res;
    int          m_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_hi   <= '0;   m_lo   <= '0;   m_left <= 0;
            p_dz   <= 1'b0; p_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_left <= 0;
                if (p_dz) m_dz <= 1'b1;
                else begin
                    m_hi <= p_res[63:32];
                    m_lo <= p_res[31:0];
                end
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (start && !m_done) begin
                p_res  <= ref_result(op, a, b);
                p_dz   <= op[1] && (b == 0);
                m_dz   <= 1'b0;
                m_busy <= 1'b1;
                m_left <= (op[1] && (b == 0)) ? 2 : W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", {63'b0, busy}, {63'b0, m_busy});
            check("done", {63'b0, done}, {63'b0, m_done});
            check("div_zero", {63'b0, div_zero}, {63'b0, m_dz});
            check("hi", {32'b0, hi}, {32'b0, m_hi});
            check("lo", {32'b0, lo}, {32'b0, m_lo});
        end
    end

    // Launches one operation; lat counts edges from the accepting edge to the edge that raises done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit noise, output int lat, output logic dz_acc);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start  = 1'b0;
        dz_acc = div_zero;
        lat    = 0;
        while (lat < 100) begin
            if (noise && (lat == 5 || lat == 20)) begin
                start = 1'b1;
                op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        start = 1'b0;
        if (noise) begin
            start = 1'b1; op = 2'd1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            start = 1'b0;
            check("start_in_done_ignored", {63'b0, busy}, 64'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic dz;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #12;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_dz", {63'b0, div_zero}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        #5 reset = 1'b0;

        // 1: signed multiply, full latency
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, dz);
        check("t1_lat", 64'(lat), 64'd33);
        check("t1_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        check("t1_lo", {32'b0, lo}, 64'hFFFF_FFEB);

        // 2: multu vs mult on the same operands
        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, lat, dz);
        check("t2u_hi", {32'b0, hi}, 64'h0000_0001);
        check("t2u_lo", {32'b0, lo}, 64'hFFFF_FFFE);
        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, lat, dz);
        check("t2s_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        check("t2s_lo", {32'b0, lo}, 64'hFFFF_FFFE);

        // 3: divides, including MIN / -1
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, dz);
        check("t3a_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        check("t3a_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        run_op(2'd3, 32'hFFFF_FFFF, 32'd16, 1'b0, lat, dz);
        check("t3b_lo", {32'b0, lo}, 64'h0FFF_FFFF);
        check("t3b_hi", {32'b0, hi}, 64'h0000_000F);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, dz);
        check("t3c_lo", {32'b0, lo}, 64'h8000_0000);
        check("t3c_hi", {32'b0, hi}, 64'h0);
        check("t3c_dz", {63'b0, div_zero}, 64'd0);

        // 4: divide by zero keeps hi/lo, next start clears the flag
        run_op(2'd0, 32'd5, 32'd6, 1'b0, lat, dz);
        check("t4_pre_lo", {32'b0, lo}, 64'd30);
        run_op(2'd2, 32'd9, 32'd0, 1'b0, lat, dz);
        check("t4_lat", 64'(lat), 64'd2);
        check("t4_dz", {63'b0, div_zero}, 64'd1);
        check("t4_hi", {32'b0, hi}, 64'd0);
        check("t4_lo", {32'b0, lo}, 64'd30);
        run_op(2'd3, 32'd9, 32'd4, 1'b0, lat, dz);
        check("t4_dz_cleared", {63'b0, dz}, 64'd0);
        check("t4_next_lo", {32'b0, lo}, 64'd2);

        // 5: starts while busy and during done are ignored
        run_op(2'd0, 32'd3, 32'd4, 1'b1, lat, dz);
        check("t5_lat", 64'(lat), 64'd33);
        check("t5_lo", {32'b0, lo}, 64'd12);
        check("t5_hi", {32'b0, hi}, 64'd0);

        // 6: asynchronous reset in the middle of a divide
        @(posedge clk); #1;
        start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("t6_busy", {63'b0, busy}, 64'd0);
        check("t6_done", {63'b0, done}, 64'd0);
        check("t6_dz", {63'b0, div_zero}, 64'd0);
        check("t6_hi", {32'b0, hi}, 64'd0);
        check("t6_lo", {32'b0, lo}, 64'd0);
        #2 reset = 1'b0;
        run_op(2'd0, 32'd7, 32'd8, 1'b0, lat, dz);
        check("t6_lat", 64'(lat), 64'd33);
        check("t6_lo_after", {32'b0, lo}, 64'd56);

        // Random operations; values are checked every cycle by the compare process.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, ($urandom_range(0, 3) == 0), lat, dz);
            check("rand_lat", 64'(lat), (ro[1] && rb == 0) ? 64'd2 : 64'd33);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
